// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 inverse cipher: one inverse round per clock. K10 is derived by forward
// expansion, then the key schedule is stepped backwards alongside the state rounds.
module aes128_inv_cipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] master_key,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} state_t;

    state_t       state_reg, state_next;
    logic [127:0] st_reg, st_next;
    logic [127:0] rk_reg, rk_next;
    logic [127:0] pt_reg, pt_next;
    logic [7:0]   rcon_reg, rcon_next;
    logic [3:0]   cnt_reg, cnt_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        return (a == 8'h1b) ? 8'h80 : {1'b0, a[7:1]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), so the S-boxes need no lookup tables.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            r = gf_mul(r, r);
            r = gf_mul(r, a);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    // State path: InvShiftRows folded into the byte select, then InvSubBytes and AddRoundKey
    logic [127:0] ark;
    logic [127:0] imc;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_isb
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = R + 4 * ((C - R + 4) % 4);
            assign ark[127-8*gi -: 8] = sbox_inv(st_reg[127-8*SRC -: 8]) ^ rk_reg[127-8*gi -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_imc
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[127-32*gi -: 8];
            assign a1 = ark[119-32*gi -: 8];
            assign a2 = ark[111-32*gi -: 8];
            assign a3 = ark[103-32*gi -: 8];
            assign imc[127-32*gi -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
    endgenerate

    // Key path: one shared SubWord(RotWord()) serves both the forward and the backward step
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sb_in, sb_rot, sw;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] rk_fwd, rk_inv;

    assign {w0, w1, w2, w3} = rk_reg;
    assign sb_in  = (state_reg == KEYEXP) ? w3 : (w3 ^ w2);
    assign sb_rot = {sb_in[23:0], sb_in[31:24]};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_ksb
            assign sw[31-8*gi -: 8] = sbox_fwd(sb_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign f0     = w0 ^ sw ^ {rcon_reg, 24'h0};
    assign f1     = f0 ^ w1;
    assign f2     = f1 ^ w2;
    assign f3     = f2 ^ w3;
    assign rk_fwd = {f0, f1, f2, f3};
    assign rk_inv = {w0 ^ sw ^ {rcon_reg, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    always_comb begin
        state_next = state_reg;
        st_next    = st_reg;
        rk_next    = rk_reg;
        pt_next    = pt_reg;
        rcon_next  = rcon_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    st_next    = ciphertext;
                    rk_next    = master_key;
                    rcon_next  = 8'h01;
                    cnt_next   = 4'd0;
                    state_next = KEYEXP;
                end else begin
                    state_next = IDLE;
                end
            end
            KEYEXP: begin
                rk_next  = rk_fwd;
                cnt_next = cnt_reg + 4'd1;
                // Hold rcon at 8'h36 on the last step: that is the value the first backward step needs
                if (cnt_reg == 4'd9) begin
                    state_next = INIT;
                end else begin
                    rcon_next = xtime(rcon_reg);
                end
            end
            INIT: begin
                st_next    = st_reg ^ rk_reg;
                rk_next    = rk_inv;
                rcon_next  = inv_xtime(rcon_reg);
                cnt_next   = 4'd9;
                state_next = ROUND;
            end
            ROUND: begin
                st_next   = imc;
                rk_next   = rk_inv;
                rcon_next = inv_xtime(rcon_reg);
                cnt_next  = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = FINAL;
            end
            FINAL: begin
                st_next    = ark;
                pt_next    = ark;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            st_reg    <= '0;
            rk_reg    <= '0;
            pt_reg    <= '0;
            rcon_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            st_reg    <= st_next;
            rk_reg    <= rk_next;
            pt_reg    <= pt_next;
            rcon_reg  <= rcon_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign plaintext = pt_reg;
    assign busy      = (state_reg == KEYEXP) || (state_reg == INIT) ||
                       (state_reg == ROUND)  || (state_reg == FINAL);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Directed bench for aes128_inv_cipher: FIPS-197 and SP800-38A vectors, latency, back-to-back,
// start-while-busy and mid-operation reset.
module tb_aes128_inv_cipher;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] master_key;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc;
    int pulses;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C3  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C4  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] P4  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    aes128_inv_cipher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .master_key (master_key),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Start is sampled at the next edge; inputs are scrambled afterwards to prove they are latched
    task automatic accept(input logic [127:0] k, input logic [127:0] c);
        master_key = k;
        ciphertext = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        master_key = ~k;
        ciphertext = ~c;
    endtask

    // Advances edges until done is seen or the budget runs out; n counts edges since the accept
    task automatic wait_done(input int from, output int n);
        n = from;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        ciphertext = '0;
        master_key = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pt", plaintext, '0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: FIPS C.1
        accept(K1, C1);
        chk("t1_busy_after_accept", {127'd0, busy}, 128'd1);
        wait_done(0, cyc);
        chk("t1_latency", 128'(cyc), 128'd21);
        chk("t1_pt", plaintext, P1);
        @(posedge clk);
        #1;
        chk("t1_done_one_cycle", {127'd0, done}, 128'd0);
        chk("t1_pt_hold_idle", plaintext, P1);

        // T2: FIPS App.B with K10 visible at INIT
        accept(K2, C2);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_k10_at_init", dut.rk_reg, K10);
        chk("t2_pt_hold_during_op", plaintext, P1);
        wait_done(10, cyc);
        chk("t2_latency", 128'(cyc), 128'd21);
        chk("t2_pt", plaintext, P2);

        // T3: back-to-back, second start raised in the DONE cycle
        accept(K1, C1);
        wait_done(0, cyc);
        chk("t3a_latency", 128'(cyc), 128'd21);
        chk("t3a_pt", plaintext, P1);
        accept(K2, C2);
        chk("t3_done_dropped", {127'd0, done}, 128'd0);
        chk("t3_busy_again", {127'd0, busy}, 128'd1);
        wait_done(0, cyc);
        chk("t3b_latency", 128'(cyc), 128'd21);
        chk("t3b_pt", plaintext, P2);
        @(posedge clk);
        #1;

        // T4: garbage start pulse while busy must be ignored
        accept(K1, C1);
        repeat (4) @(posedge clk);
        #1;
        master_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        ciphertext = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, cyc);
        chk("t4_latency", 128'(cyc), 128'd21);
        chk("t4_pt", plaintext, P1);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("t4_single_done", 128'(pulses), 128'd0);

        // T5: asynchronous reset during ROUND
        accept(K1, C1);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_pt_zero", plaintext, '0);
        chk("t5_busy_zero", {127'd0, busy}, 128'd0);
        chk("t5_done_zero", {127'd0, done}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("t5_no_activity", 128'(pulses), 128'd0);
        chk("t5_pt_still_zero", plaintext, '0);
        accept(K2, C2);
        wait_done(0, cyc);
        chk("t5_fresh_latency", 128'(cyc), 128'd21);
        chk("t5_fresh_pt", plaintext, P2);

        // Extra known-answer vectors (SP800-38A ECB-AES128)
        accept(K2, C3);
        wait_done(0, cyc);
        chk("kat3_pt", plaintext, P3);
        accept(K2, C4);
        wait_done(0, cyc);
        chk("kat4_latency", 128'(cyc), 128'd21);
        chk("kat4_pt", plaintext, P4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
